// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter
//    Round-robin arbiter feeding a one-hot to binary encoder. Request pulses
//    are collected into a sticky pending register; one source at a time is
//    granted and the grant is held until the consumer signals done.
//
// Ports
//    clk          rising-edge clock
//    rst          synchronous, active-high reset
//    req[N]       request pulses or levels, bit k = source k
//    done         consumer finished with current grant (ignored when idle)
//    grant[N]     registered one-hot grant, all-zero when idle
//    grant_valid  high while a grant is held
//    grant_idx    binary index of the granted source, 0 when idle
//    pending[N]   latched outstanding requests
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant held; picks a winner from pending if any is set
// GRANT | grant held stable until done, then clears and returns idle

module rr_onehot_arbiter #(
   parameter int N    = 8,
   parameter int IDXW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            done,
   output logic [N-1:0]    grant,
   output logic            grant_valid,
   output logic [IDXW-1:0] grant_idx,
   output logic [N-1:0]    pending
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state;
   logic [IDXW-1:0] ptr;
   logic [N-1:0]    clr;
   logic [IDXW-1:0] win_idx;
   logic            win_found;

   // Only the currently granted bit is released, and only when the
   // consumer reports done. A fresh req in the same cycle re-sets it below.
   always_comb begin
      clr = '0;
      if (state == GRANT && done) begin
         clr = grant;
      end
   end

   // Wrap-around priority scan starting at ptr: the first pending bit found
   // at ptr, ptr+1, ..., N-1, 0, ..., ptr-1 wins.
   always_comb begin : win_scan
      int unsigned pos;
      win_idx   = '0;
      win_found = 1'b0;
      pos       = 0;
      for (int i = 0; i < N; i++) begin
         pos = (int'(ptr) + i) % N;
         if (!win_found && pending[pos]) begin
            win_idx   = IDXW'(pos);
            win_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         pending     <= '0;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
      end else begin
         pending <= (pending & ~clr) | req;

         case (state)
            IDLE: begin
               if (win_found) begin
                  grant       <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                  grant_idx   <= win_idx;
                  grant_valid <= 1'b1;
                  state       <= GRANT;
               end else begin
                  grant       <= '0;
                  grant_idx   <= '0;
                  grant_valid <= 1'b0;
               end
            end

            GRANT: begin
               if (done) begin
                  // Advance past the source just served so it drops to
                  // lowest priority for the next scan.
                  if (int'(grant_idx) == N - 1) begin
                     ptr <= '0;
                  end else begin
                     ptr <= grant_idx + 1'b1;
                  end
                  grant       <= '0;
                  grant_idx   <= '0;
                  grant_valid <= 1'b0;
                  state       <= IDLE;
               end
            end

            default: begin
               state       <= IDLE;
               grant       <= '0;
               grant_idx   <= '0;
               grant_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
